// File: rtl/ppu_pkg.sv
// Shared constants for the PPU CPU-register interface: register indices, palette page, DMA states.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL    = 3'h0;
  localparam logic [2:0] REG_MASK    = 3'h1;
  localparam logic [2:0] REG_STATUS  = 3'h2;
  localparam logic [2:0] REG_OAMADDR = 3'h3;
  localparam logic [2:0] REG_OAMDATA = 3'h4;
  localparam logic [2:0] REG_SCROLL  = 3'h5;
  localparam logic [2:0] REG_ADDR    = 3'h6;
  localparam logic [2:0] REG_DATA    = 3'h7;

  localparam logic [5:0] PAL_PAGE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies one 256-byte page into OAM, one read plus DMA_RD_LAT wait then one write per byte.
// stall_out is high in every non-IDLE state; a new request while busy is dropped.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int OAM_AW     = 8,
  parameter int DMA_RD_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dma_wr_in,
  input  logic [7:0]        dma_page_in,
  input  logic [7:0]        dma_d_in,
  output logic [15:0]       dma_addr_out,
  output logic              dma_rd_out,
  output logic              stall_out,
  output logic              oam_wr_out,
  output logic [OAM_AW-1:0] oam_ofs_out,
  output logic [7:0]        oam_d_out
);

  localparam logic [1:0]        LAT_LAST = 2'(DMA_RD_LAT - 1);
  localparam logic [OAM_AW-1:0] CNT_LAST = '1;

  dma_state_t        state_q, state_d;
  logic [7:0]        page_q;
  logic [OAM_AW-1:0] cnt_q;
  logic [1:0]        lat_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && dma_wr_in) begin
        page_q <= dma_page_in;
        cnt_q  <= '0;
      end
      if (state_q == RD) lat_q <= (lat_q == LAT_LAST) ? 2'd0 : lat_q + 2'd1;
      if (state_q == WR) cnt_q <= cnt_q + OAM_AW'(1);
    end
  end

  // The read strobe fires only on the first RD cycle; the rest is read-latency wait.
  always_comb begin
    state_d    = state_q;
    dma_rd_out = 1'b0;
    oam_wr_out = 1'b0;
    unique case (state_q)
      IDLE: if (dma_wr_in) state_d = RD;
      RD: begin
        dma_rd_out = (lat_q == 2'd0);
        if (lat_q == LAT_LAST) state_d = WR;
      end
      WR: begin
        oam_wr_out = 1'b1;
        state_d    = (cnt_q == CNT_LAST) ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_addr_out = {page_q, 8'h00} + 16'(cnt_q);
  assign stall_out    = (state_q != IDLE);
  assign oam_ofs_out  = cnt_q;
  assign oam_d_out    = dma_d_in;

endmodule

// File: rtl/ppu_reg_if.sv
// PPU CPU-register interface ($2000-$2007): scroll/VRAM pointer, buffered reads, vblank/NMI, OAM port with DMA.
// Accesses act once per enable_in falling edge; strobes and read data appear the following cycle.
module ppu_reg_if
  import ppu_pkg::*;
#(
  parameter int OAM_AW     = 8,
  parameter int VRAM_AW    = 14,
  parameter int DMA_RD_LAT = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic [2:0]         select_in,
  input  logic               rw_select_in,
  input  logic [7:0]         cpu_data_in,
  output logic [7:0]         cpu_data_out,
  input  logic               vblank_in,
  input  logic               spr_of_in,
  input  logic               spr_0_hit_in,
  input  logic [7:0]         vram_d_in,
  input  logic [7:0]         pram_d_in,
  input  logic [7:0]         oam_d_in,
  output logic [VRAM_AW-1:0] vram_addr_out,
  output logic [7:0]         vram_d_out,
  output logic               vram_wr_out,
  output logic               pram_wr_out,
  output logic               vram_rd_out,
  output logic [OAM_AW-1:0]  oam_addr_out,
  output logic [7:0]         oam_d_out,
  output logic               oam_wr_out,
  output logic [14:0]        t_addr_out,
  output logic [2:0]         fh_out,
  output logic               upd_cntrs_out,
  output logic [7:0]         ctrl_out,
  output logic [7:0]         mask_out,
  output logic               nmi_out,
  input  logic               dma_wr_in,
  input  logic [7:0]         dma_page_in,
  output logic [15:0]        dma_addr_out,
  output logic               dma_rd_out,
  input  logic [7:0]         dma_d_in,
  output logic               stall_out
);

  logic              q_enable_in, q_vblank_in;
  logic              w_q, vblank_q, rd_cap_q;
  logic [7:0]        rd_buf, rd_latch, rd_val;
  logic              cpu_oam_wr_q;
  logic [7:0]        cpu_oam_d_q;
  logic [OAM_AW-1:0] oam_addr_q;
  logic              dma_oam_wr;
  logic [OAM_AW-1:0] dma_oam_ofs;
  logic [7:0]        dma_oam_d;
  logic              ev, ev_rd, ev_wr, is_pal, vb_rise, vb_fall;
  logic [VRAM_AW-1:0] v_step;
  logic [14:0]       t_new;

  assign ev      = q_enable_in & ~enable_in;
  assign ev_rd   = ev & rw_select_in;
  assign ev_wr   = ev & ~rw_select_in;
  assign is_pal  = (vram_addr_out[13:8] == PAL_PAGE);
  assign vb_rise = vblank_in & ~q_vblank_in;
  assign vb_fall = ~vblank_in & q_vblank_in;
  assign v_step  = ctrl_out[2] ? VRAM_AW'(32) : VRAM_AW'(1);
  assign t_new   = {t_addr_out[14:8], cpu_data_in};

  always_comb begin
    rd_val = 8'h00;
    unique case (select_in)
      REG_STATUS:  rd_val = {vblank_q, spr_0_hit_in, spr_of_in, 5'b0};
      REG_OAMDATA: rd_val = oam_d_in;
      REG_DATA:    rd_val = is_pal ? pram_d_in : rd_buf;
      default:     rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_enable_in   <= 1'b1;
      q_vblank_in   <= 1'b0;
      w_q           <= 1'b0;
      vblank_q      <= 1'b0;
      rd_cap_q      <= 1'b0;
      rd_buf        <= '0;
      rd_latch      <= '0;
      cpu_oam_wr_q  <= 1'b0;
      cpu_oam_d_q   <= '0;
      oam_addr_q    <= '0;
      vram_addr_out <= '0;
      vram_d_out    <= '0;
      vram_wr_out   <= 1'b0;
      pram_wr_out   <= 1'b0;
      vram_rd_out   <= 1'b0;
      t_addr_out    <= '0;
      fh_out        <= '0;
      upd_cntrs_out <= 1'b0;
      ctrl_out      <= '0;
      mask_out      <= '0;
      nmi_out       <= 1'b0;
    end else begin
      q_enable_in   <= enable_in;
      q_vblank_in   <= vblank_in;
      nmi_out       <= vblank_q & ctrl_out[7];
      vram_wr_out   <= 1'b0;
      pram_wr_out   <= 1'b0;
      vram_rd_out   <= 1'b0;
      upd_cntrs_out <= 1'b0;
      cpu_oam_wr_q  <= 1'b0;

      // VRAM data arrives the cycle after the read strobe; v advances only once the access is done.
      rd_cap_q <= vram_rd_out;
      if (rd_cap_q) rd_buf <= vram_d_in;
      if (vram_wr_out | pram_wr_out | rd_cap_q) vram_addr_out <= vram_addr_out + v_step;
      if (cpu_oam_wr_q) oam_addr_q <= oam_addr_q + OAM_AW'(1);

      if (vb_fall || (ev_rd && select_in == REG_STATUS)) vblank_q <= 1'b0;
      else if (vb_rise)                                  vblank_q <= 1'b1;

      if (ev_rd) begin
        rd_latch <= rd_val;
        if (select_in == REG_STATUS) w_q <= 1'b0;
        if (select_in == REG_DATA)   vram_rd_out <= 1'b1;
      end

      if (ev_wr) begin
        case (select_in)
          REG_CTRL: begin
            ctrl_out          <= cpu_data_in;
            t_addr_out[11:10] <= cpu_data_in[1:0];
          end
          REG_MASK:    mask_out   <= cpu_data_in;
          REG_OAMADDR: oam_addr_q <= OAM_AW'(cpu_data_in);
          REG_OAMDATA: begin
            if (!stall_out) begin
              cpu_oam_wr_q <= 1'b1;
              cpu_oam_d_q  <= cpu_data_in;
            end
          end
          REG_SCROLL: begin
            if (!w_q) begin
              fh_out          <= cpu_data_in[2:0];
              t_addr_out[4:0] <= cpu_data_in[7:3];
            end else begin
              t_addr_out[14:12] <= cpu_data_in[2:0];
              t_addr_out[9:5]   <= cpu_data_in[7:3];
            end
            w_q <= ~w_q;
          end
          REG_ADDR: begin
            if (!w_q) begin
              t_addr_out[13:8] <= cpu_data_in[5:0];
              t_addr_out[14]   <= 1'b0;
            end else begin
              t_addr_out[7:0] <= cpu_data_in;
              vram_addr_out   <= VRAM_AW'(t_new);
              upd_cntrs_out   <= 1'b1;
            end
            w_q <= ~w_q;
          end
          REG_DATA: begin
            vram_d_out <= cpu_data_in;
            if (is_pal) pram_wr_out <= 1'b1;
            else        vram_wr_out <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_data_out = (!enable_in && rw_select_in) ? rd_latch : 8'h00;

  ppu_oam_dma #(
    .OAM_AW     (OAM_AW),
    .DMA_RD_LAT (DMA_RD_LAT)
  ) u_dma (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .dma_wr_in    (dma_wr_in),
    .dma_page_in  (dma_page_in),
    .dma_d_in     (dma_d_in),
    .dma_addr_out (dma_addr_out),
    .dma_rd_out   (dma_rd_out),
    .stall_out    (stall_out),
    .oam_wr_out   (dma_oam_wr),
    .oam_ofs_out  (dma_oam_ofs),
    .oam_d_out    (dma_oam_d)
  );

  // DMA owns the OAM write port on its write cycles; CPU writes are refused while it is busy.
  assign oam_wr_out   = dma_oam_wr | cpu_oam_wr_q;
  assign oam_d_out    = dma_oam_wr ? dma_oam_d : cpu_oam_d_q;
  assign oam_addr_out = dma_oam_wr ? oam_addr_q + dma_oam_ofs : oam_addr_q;

endmodule

// File: tb/tb_ppu_reg_if.sv
// Self-checking bench for ppu_reg_if: memory models feed observation queues compared against expectation queues.
module tb_ppu_reg_if;
  import ppu_pkg::*;

  localparam int LAT = 1;

  logic        clk_in = 1'b0, rst_in = 1'b1, enable_in = 1'b1, rw_select_in = 1'b1;
  logic [2:0]  select_in = '0;
  logic [7:0]  cpu_data_in = '0, cpu_data_out;
  logic        vblank_in = 1'b0, spr_of_in = 1'b0, spr_0_hit_in = 1'b0;
  logic [7:0]  vram_d_in, pram_d_in, oam_d_in, vram_d_out, oam_d_out, ctrl_out, mask_out;
  logic [13:0] vram_addr_out;
  logic        vram_wr_out, pram_wr_out, vram_rd_out, oam_wr_out, upd_cntrs_out, nmi_out;
  logic [7:0]  oam_addr_out;
  logic [14:0] t_addr_out;
  logic [2:0]  fh_out;
  logic        dma_wr_in = 1'b0, dma_rd_out, stall_out;
  logic [7:0]  dma_page_in = '0, dma_d_in;
  logic [15:0] dma_addr_out;

  int total = 0, bad = 0, upd_cnt = 0;

  logic [7:0]  vram_mem [16384];
  logic [7:0]  pram_mem [32];
  logic [7:0]  oam_mem  [256];
  logic [21:0] vw_obs[$], vw_exp[$], pw_obs[$], pw_exp[$];
  logic [15:0] ow_obs[$], ow_exp[$], da_obs[$];
  logic [7:0]  rd_exp[$];

  always #5 clk_in = ~clk_in;

  ppu_reg_if #(.OAM_AW(8), .VRAM_AW(14), .DMA_RD_LAT(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .select_in(select_in),
    .rw_select_in(rw_select_in), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .vblank_in(vblank_in), .spr_of_in(spr_of_in), .spr_0_hit_in(spr_0_hit_in),
    .vram_d_in(vram_d_in), .pram_d_in(pram_d_in), .oam_d_in(oam_d_in),
    .vram_addr_out(vram_addr_out), .vram_d_out(vram_d_out), .vram_wr_out(vram_wr_out),
    .pram_wr_out(pram_wr_out), .vram_rd_out(vram_rd_out), .oam_addr_out(oam_addr_out),
    .oam_d_out(oam_d_out), .oam_wr_out(oam_wr_out), .t_addr_out(t_addr_out), .fh_out(fh_out),
    .upd_cntrs_out(upd_cntrs_out), .ctrl_out(ctrl_out), .mask_out(mask_out), .nmi_out(nmi_out),
    .dma_wr_in(dma_wr_in), .dma_page_in(dma_page_in), .dma_addr_out(dma_addr_out),
    .dma_rd_out(dma_rd_out), .dma_d_in(dma_d_in), .stall_out(stall_out)
  );

  // Memory models: synchronous VRAM, combinational palette/OAM, DMA source byte = low address byte.
  always @(posedge clk_in) begin
    if (vram_rd_out) vram_d_in <= vram_mem[vram_addr_out];
    if (vram_wr_out) begin
      vram_mem[vram_addr_out] <= vram_d_out;
      vw_obs.push_back({vram_addr_out, vram_d_out});
    end
    if (pram_wr_out) begin
      pram_mem[vram_addr_out[4:0]] <= vram_d_out;
      pw_obs.push_back({vram_addr_out, vram_d_out});
    end
    if (oam_wr_out) begin
      oam_mem[oam_addr_out] <= oam_d_out;
      ow_obs.push_back({oam_addr_out, oam_d_out});
    end
    if (dma_rd_out) begin
      dma_d_in <= dma_addr_out[7:0];
      da_obs.push_back(dma_addr_out);
    end
    if (upd_cntrs_out) upd_cnt++;
  end

  assign pram_d_in = pram_mem[vram_addr_out[4:0]];
  assign oam_d_in  = oam_mem[oam_addr_out];

  task automatic cpu_acc(input logic [2:0] sel, input logic rw, input logic [7:0] d,
                         input int hold, output logic [7:0] q);
    @(negedge clk_in);
    select_in = sel; rw_select_in = rw; cpu_data_in = d; enable_in = 1'b0;
    repeat (hold) @(negedge clk_in);
    q = cpu_data_out;
    enable_in = 1'b1; rw_select_in = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic cpu_wr(input logic [2:0] sel, input logic [7:0] d);
    logic [7:0] q;
    cpu_acc(sel, 1'b0, d, 1, q);
  endtask

  task automatic cpu_rd(input logic [2:0] sel, output logic [7:0] q);
    cpu_acc(sel, 1'b1, 8'h00, 1, q);
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++; if ({ctrl_out, mask_out, cpu_data_out} !== 24'h0) begin bad++; $display("FAIL reset_regs got %h expected 0", {ctrl_out, mask_out, cpu_data_out}); end
    total++; if ({vram_addr_out, oam_addr_out} !== 22'h0) begin bad++; $display("FAIL reset_addr got %h expected 0", {vram_addr_out, oam_addr_out}); end
    total++; if ({t_addr_out, fh_out} !== 18'h0) begin bad++; $display("FAIL reset_scroll got %h expected 0", {t_addr_out, fh_out}); end
    total++; if ({vram_wr_out, pram_wr_out, vram_rd_out, oam_wr_out, upd_cntrs_out, nmi_out, stall_out, dma_rd_out} !== 8'h0) begin
      bad++; $display("FAIL reset_strobes got %b expected 0", {vram_wr_out, pram_wr_out, vram_rd_out, oam_wr_out, upd_cntrs_out, nmi_out, stall_out, dma_rd_out});
    end
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    total++; if (vw_obs.size() + ow_obs.size() + pw_obs.size() != 0) begin bad++; $display("FAIL reset_idle_writes got %0d expected 0", vw_obs.size() + ow_obs.size() + pw_obs.size()); end
  endtask

  task automatic test_scroll_addr;
    int u0;
    vw_obs.delete();
    cpu_wr(REG_CTRL, 8'h00);
    cpu_wr(REG_MASK, 8'h1E);
    total++; if (mask_out !== 8'h1E) begin bad++; $display("FAIL mask got %h expected 1e", mask_out); end
    u0 = upd_cnt;
    cpu_wr(REG_ADDR, 8'h21);
    cpu_wr(REG_ADDR, 8'h08);
    total++; if (t_addr_out !== 15'h2108) begin bad++; $display("FAIL t_after_2006 got %h expected 2108", t_addr_out); end
    total++; if (vram_addr_out !== 14'h2108) begin bad++; $display("FAIL v_after_2006 got %h expected 2108", vram_addr_out); end
    vw_exp.push_back({14'h2108, 8'h55}); cpu_wr(REG_DATA, 8'h55);
    vw_exp.push_back({14'h2109, 8'h66}); cpu_wr(REG_DATA, 8'h66);
    total++; if (upd_cnt - u0 != 1) begin bad++; $display("FAIL upd_pulses got %0d expected 1", upd_cnt - u0); end
    total++; if (vw_obs.size() != 2) begin bad++; $display("FAIL vram_wr_count got %0d expected 2", vw_obs.size()); end
    while (vw_exp.size() > 0 && vw_obs.size() > 0) begin
      logic [21:0] e, o;
      e = vw_exp.pop_front(); o = vw_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL vram_wr got %h expected %h", o, e); end
    end
    vw_exp.delete();
    total++; if (vram_addr_out !== 14'h210A) begin bad++; $display("FAIL v_after_2007 got %h expected 210a", vram_addr_out); end
  endtask

  task automatic test_buffered_read;
    logic [7:0] q, e;
    cpu_wr(REG_ADDR, 8'h20); cpu_wr(REG_ADDR, 8'h00);
    cpu_wr(REG_DATA, 8'hAA); cpu_wr(REG_DATA, 8'hBB);
    cpu_wr(REG_ADDR, 8'h20); cpu_wr(REG_ADDR, 8'h00);
    rd_exp.push_back(8'h00); rd_exp.push_back(8'hAA);
    for (int i = 0; i < 2; i++) begin
      cpu_rd(REG_DATA, q);
      e = rd_exp.pop_front();
      total++; if (q !== e) begin bad++; $display("FAIL buf_read%0d got %h expected %h", i, q, e); end
    end
    total++; if (vram_addr_out !== 14'h2002) begin bad++; $display("FAIL v_after_reads got %h expected 2002", vram_addr_out); end
  endtask

  task automatic test_palette;
    logic [7:0] q, e;
    pw_obs.delete();
    cpu_wr(REG_CTRL, 8'h00);
    cpu_wr(REG_ADDR, 8'h3F); cpu_wr(REG_ADDR, 8'h01);
    pw_exp.push_back({14'h3F01, 8'h1C});
    vw_obs.delete();
    cpu_wr(REG_DATA, 8'h1C);
    total++; if (pw_obs.size() != 1 || vw_obs.size() != 0) begin bad++; $display("FAIL pal_wr_route got pram=%0d vram=%0d expected pram=1 vram=0", pw_obs.size(), vw_obs.size()); end
    if (pw_obs.size() > 0) begin
      logic [21:0] pe, po;
      pe = pw_exp.pop_front(); po = pw_obs.pop_front();
      total++; if (po !== pe) begin bad++; $display("FAIL pal_wr got %h expected %h", po, pe); end
    end
    pw_exp.delete();
    cpu_wr(REG_CTRL, 8'h04);
    cpu_wr(REG_ADDR, 8'h3F); cpu_wr(REG_ADDR, 8'h01);
    rd_exp.push_back(8'h1C);
    cpu_rd(REG_DATA, q);
    e = rd_exp.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL pal_read got %h expected %h", q, e); end
    total++; if (vram_addr_out !== 14'h3F21) begin bad++; $display("FAIL pal_v_inc32 got %h expected 3f21", vram_addr_out); end
  endtask

  task automatic test_status;
    logic [7:0] q, e;
    cpu_wr(REG_CTRL, 8'h80);
    @(negedge clk_in); vblank_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++; if (nmi_out !== 1'b1) begin bad++; $display("FAIL nmi_set got %b expected 1", nmi_out); end
    cpu_wr(REG_SCROLL, 8'h00);
    rd_exp.push_back(8'h80);
    cpu_rd(REG_STATUS, q);
    e = rd_exp.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL status_vbl got %h expected %h", q, e); end
    total++; if (nmi_out !== 1'b0) begin bad++; $display("FAIL nmi_clear got %b expected 0", nmi_out); end
    cpu_wr(REG_SCROLL, 8'hFD);
    total++; if (fh_out !== 3'd5 || t_addr_out[4:0] !== 5'h1F) begin bad++; $display("FAIL w_reset_scroll got fh=%0d tx=%h expected fh=5 tx=1f", fh_out, t_addr_out[4:0]); end
    spr_0_hit_in = 1'b1; spr_of_in = 1'b1;
    rd_exp.push_back(8'h60);
    cpu_rd(REG_STATUS, q);
    e = rd_exp.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL status_spr got %h expected %h", q, e); end
    spr_0_hit_in = 1'b0; spr_of_in = 1'b0;
    vblank_in = 1'b0; repeat (2) @(negedge clk_in);
    vblank_in = 1'b1; repeat (3) @(negedge clk_in);
    vblank_in = 1'b0; repeat (3) @(negedge clk_in);
    rd_exp.push_back(8'h00);
    cpu_rd(REG_STATUS, q);
    e = rd_exp.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL status_fall_clear got %h expected %h", q, e); end
    cpu_wr(REG_CTRL, 8'h00);
  endtask

  task automatic test_dma;
    int stall_cnt, guard;
    logic [7:0] q;
    cpu_wr(REG_OAMADDR, 8'h10);
    ow_obs.delete(); da_obs.delete();
    for (int i = 0; i < 256; i++) ow_exp.push_back({8'(16 + i), 8'(i)});
    @(negedge clk_in); dma_page_in = 8'h02; dma_wr_in = 1'b1;
    @(negedge clk_in); dma_wr_in = 1'b0;
    stall_cnt = 0; guard = 0;
    fork
      begin
        while (stall_out === 1'b1 && guard < 2000) begin
          stall_cnt++; guard++;
          @(negedge clk_in);
        end
      end
      begin
        repeat (20) @(negedge clk_in);
        dma_page_in = 8'h05; dma_wr_in = 1'b1;
        @(negedge clk_in); dma_wr_in = 1'b0;
        cpu_wr(REG_OAMDATA, 8'hEE);
      end
    join
    total++; if (stall_cnt != 256 * (LAT + 1)) begin bad++; $display("FAIL dma_stall_cycles got %0d expected %0d", stall_cnt, 256 * (LAT + 1)); end
    total++; if (ow_obs.size() != 256) begin bad++; $display("FAIL dma_wr_count got %0d expected 256", ow_obs.size()); end
    while (ow_exp.size() > 0 && ow_obs.size() > 0) begin
      logic [15:0] e, o;
      e = ow_exp.pop_front(); o = ow_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL dma_oam_wr got %h expected %h", o, e); end
    end
    ow_exp.delete();
    for (int i = 0; i < da_obs.size() && i < 256; i++) begin
      total++; if (da_obs[i] !== {8'h02, 8'(i)}) begin bad++; $display("FAIL dma_addr%0d got %h expected %h", i, da_obs[i], {8'h02, 8'(i)}); end
    end
    total++; if (oam_addr_out !== 8'h10) begin bad++; $display("FAIL dma_oam_addr_kept got %h expected 10", oam_addr_out); end
    cpu_wr(REG_OAMADDR, 8'h15);
    for (int k = 0; k < 2; k++) begin
      cpu_rd(REG_OAMDATA, q);
      total++; if (q !== 8'h05) begin bad++; $display("FAIL oam_read%0d got %h expected 05", k, q); end
    end
  endtask

  task automatic test_abort_and_hold;
    int g;
    logic [7:0] q;
    cpu_wr(REG_OAMADDR, 8'h40);
    ow_obs.delete();
    @(negedge clk_in); dma_page_in = 8'h03; dma_wr_in = 1'b1;
    @(negedge clk_in); dma_wr_in = 1'b0;
    g = 0;
    while (ow_obs.size() < 40 && g < 2000) begin @(negedge clk_in); g++; end
    total++; if (ow_obs.size() < 40) begin bad++; $display("FAIL abort_wait got %0d writes expected 40", ow_obs.size()); end
    #2 rst_in = 1'b1;
    #1;
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL abort_stall got %b expected 0", stall_out); end
    total++; if (oam_addr_out !== 8'h00) begin bad++; $display("FAIL abort_oam_addr got %h expected 00", oam_addr_out); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    total++; if (stall_out !== 1'b0 || ow_obs.size() != 40) begin bad++; $display("FAIL abort_idle got stall=%b writes=%0d expected stall=0 writes=40", stall_out, ow_obs.size()); end
    cpu_wr(REG_OAMADDR, 8'h30);
    ow_obs.delete();
    ow_exp.push_back({8'h30, 8'h77});
    cpu_acc(REG_OAMDATA, 1'b0, 8'h77, 10, q);
    total++; if (ow_obs.size() != 1) begin bad++; $display("FAIL hold_low_writes got %0d expected 1", ow_obs.size()); end
    if (ow_obs.size() > 0) begin
      logic [15:0] e, o;
      e = ow_exp.pop_front(); o = ow_obs.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL hold_low_wr got %h expected %h", o, e); end
    end
    ow_exp.delete();
    total++; if (oam_addr_out !== 8'h31) begin bad++; $display("FAIL hold_low_inc got %h expected 31", oam_addr_out); end
  endtask

  initial begin
    test_reset();
    test_scroll_addr();
    test_buffered_read();
    test_palette();
    test_status();
    test_dma();
    test_abort_and_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_reg_if.md
Name: ppu_reg_if

Overview:
Second-generation PPU CPU-register interface covering $2000-$2007, plus an integrated OAM DMA engine ($4014).
- Adds behaviour the first generation lacks: buffered $2007 reads, $2004 OAM reads, a VRAM address pointer with auto-increment, a vblank flag set on the rising edge of vblank_in, an NMI output and parametrised OAM/VRAM widths.
- Sits between the CPU bus decode and the PPU background/sprite/VRAM blocks.

Parameters:
- OAM_AW, 8, OAM address width; DMA length is 2**OAM_AW bytes.
- VRAM_AW, 14, VRAM address width; must be at least 14.
- DMA_RD_LAT, 1, cycles from dma_rd_out to valid dma_d_in; range 1..3.

Ports:
- clk_in  in  1  PPU clock.
- rst_in  in  1  asynchronous active-high reset.
- enable_in  in  1  register chip-select, active low; accesses are taken on its falling edge.
- select_in  in  3  register index $2000+n.
- rw_select_in  in  1  1 = CPU read, 0 = CPU write.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  CPU read data.
- vblank_in  in  1  vblank level from the timing block.
- spr_of_in, spr_0_hit_in  in  1  status bits for $2002.
- vram_d_in  in  8  VRAM read data; valid the cycle after vram_rd_out.
- pram_d_in  in  8  palette read data, combinational on vram_addr_out.
- oam_d_in  in  8  OAM read data at oam_addr_out, combinational.
- vram_addr_out  out  VRAM_AW  VRAM pointer v.
- vram_d_out  out  8  write data.
- vram_wr_out, pram_wr_out, vram_rd_out  out  1  single-cycle strobes.
- oam_addr_out  out  OAM_AW.
- oam_d_out  out  8.
- oam_wr_out  out  1.
- t_addr_out  out  15  scroll latch t.
- fh_out  out  3  fine-x.
- upd_cntrs_out  out  1  one-cycle strobe, t copied to counters.
- ctrl_out  out  8  last $2000 value.
- mask_out  out  8  last $2001 value.
- nmi_out  out  1.
- dma_wr_in  in  1  one-cycle $4014 write strobe.
- dma_page_in  in  8.
- dma_addr_out  out  16.
- dma_rd_out  out  1.
- dma_d_in  in  8.
- stall_out  out  1  CPU halt while DMA is active.

Behaviour:
- Reset (async): every output, state register and internal register goes to 0, except the edge-detect register for enable_in, which resets to 1. DMA FSM resets to IDLE. A reset asserted mid-DMA aborts the transfer; stall_out drops immediately.
- Access event: q_enable_in=1 and enable_in=0. Exactly one action per event; enable_in held low does not repeat the action.
- cpu_data_out: holds the latched read value while enable_in=0 and rw_select_in=1, otherwise 0. The value is latched on the event cycle and visible from the next cycle.
- W $2000: store ctrl_out; t[11:10] = d[1:0].
- W $2001: store mask_out.
- R $2002: return {vblank, spr_0_hit_in, spr_of_in, 5'b0}. Clear vblank and the write toggle w.
- W $2003: oam_addr_out = d.
- R $2004: return oam_d_in; no increment.
- W $2004: write d to OAM; oam_addr +1, wrapping at 2**OAM_AW. Ignored while the DMA is busy.
- W $2005, w=0: fh = d[2:0], t[4:0] = d[7:3].
- W $2005, w=1: t[14:12] = d[2:0], t[9:5] = d[7:3].
- Every $2005/$2006 write toggles w.
- W $2006, w=0: t[13:8] = d[5:0], t[14] = 0.
- W $2006, w=1: t[7:0] = d; v = t (low VRAM_AW bits); upd_cntrs_out pulses next cycle.
- W $2007: when v[13:8]=6'h3F pulse pram_wr_out, else pulse vram_wr_out. vram_d_out = d. Then v += ctrl_out[2] ? 32 : 1, modulo 2**VRAM_AW.
- R $2007, non-palette: return the read buffer, pulse vram_rd_out, capture vram_d_in into the buffer next cycle, then increment v.
- R $2007, palette: return pram_d_in directly; the buffer still refreshes from VRAM; increment v.
- vblank: set on a vblank_in 0->1 edge; cleared on vblank_in 1->0 or on an R $2002. If set and clear occur in the same cycle, the clear wins.
- nmi_out = vblank & ctrl_out[7], registered.
- DMA FSM: IDLE -> RD on dma_wr_in. The page is latched and the counter i is cleared.
  - RD: dma_addr_out = {page, i}; dma_rd_out pulses; wait DMA_RD_LAT cycles.
  - WR: write dma_d_in to OAM at oam_addr + i (wrapping); i++. Go to RD, or to IDLE after the last byte.
  - stall_out = 1 in every state other than IDLE.
  - oam_addr_out is unchanged after the DMA completes.
  - dma_wr_in while busy is ignored.
- Register accesses during DMA: $2000-$2003 and $2005-$2007 are processed normally.

Decomposition:
- Package ppu_pkg holds: register index constants REG_CTRL..REG_DATA (3'h0..3'h7), PAL_PAGE = 6'h3F, and the DMA state encoding IDLE/RD/WR.
- One sub-module, ppu_oam_dma: FSM, counter, page latch and stall. The parent muxes OAM write port ownership between DMA and CPU.

Test Plan:
- Scroll and address setup: W $2006=0x21, W $2006=0x08, W $2007=0x55, W $2007=0x66 with ctrl[2]=0 -> vram_wr_out at 0x2108 with 0x55, then 0x2109 with 0x66; upd_cntrs_out pulses once; t=0x2108.
- Buffered read: VRAM[0x2000]=0xAA, [0x2001]=0xBB; set v=0x2000; read $2007 twice -> first returns the stale buffer, second returns 0xAA; v ends at 0x2002.
- Palette read: v=0x3F01, pram=0x1C -> returns 0x1C immediately; ctrl[2]=1 gives v=0x3F21.
- Status read: raise vblank_in with ctrl[7]=1 -> nmi_out=1. R $2002 returns 0x80 and clears vblank; w resets, so the next $2005 write targets fh/coarse-x.
- DMA: oam_addr=0x10, dma_page=0x02, memory byte = low address byte -> OAM[(0x10+i)&0xFF]=i for i=0..255; stall_out high for exactly 256*(DMA_RD_LAT+1) cycles; oam_addr=0x10 afterwards.
- Abort and edges: reset after 40 DMA bytes -> stall_out=0 immediately and the FSM is IDLE. Hold enable_in low 10 cycles on W $2004 -> exactly one OAM write.
